// File: rtl/freq_pkg.sv
// Shared types and defaults for the frequency meter.
// State encoding, default widths and the tick-counter width helper.
package freq_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

   localparam int DEF_CNT_W = 32;
   localparam int DEF_TICKS = 1000;
   localparam int DEF_SYNC  = 2;

   function automatic int tick_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous input plus rising-edge detector.
// The rise pulse lasts one clk and trails sig_in by SYNC_STAGES clks.
module sync_edge_det
   import freq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   level;

   assign level = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev_q <= level;
      end
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Counts synchronised rising edges of sig_in over TICKS_PER_GATE gate ticks
// and publishes the saturated count with a one-clk valid strobe.
module freq_meter
   import freq_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int TICKS_PER_GATE = DEF_TICKS,
   parameter int SYNC_STAGES    = DEF_SYNC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             gate_en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             overflow
);

   localparam int            TW        = tick_w(TICKS_PER_GATE);
   localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_GATE - 1);

   state_t           state;
   logic [CNT_W-1:0] edge_cnt;
   logic [TW-1:0]    tick_cnt;
   logic             ovf;
   logic             rise;
   logic [CNT_W:0]   sum;
   logic [CNT_W-1:0] sat_cnt;
   logic             carry;
   logic             close;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .sig_in(sig_in),
      .rise  (rise)
   );

   // The closing window also absorbs an edge arriving on its last clk.
   always_comb begin
      sum     = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, rise};
      carry   = sum[CNT_W];
      sat_cnt = carry ? '1 : sum[CNT_W-1:0];
   end

   assign close = gate_en && (tick_cnt == LAST_TICK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         edge_cnt   <= '0;
         tick_cnt   <= '0;
         ovf        <= 1'b0;
         freq       <= '0;
         freq_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         freq_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (gate_en) begin
                  state    <= ST_MEASURE;
                  edge_cnt <= '0;
                  tick_cnt <= '0;
                  ovf      <= 1'b0;
               end
            end
            ST_MEASURE: begin
               if (close) begin
                  freq       <= sat_cnt;
                  overflow   <= ovf | carry;
                  freq_valid <= 1'b1;
                  edge_cnt   <= '0;
                  tick_cnt   <= '0;
                  ovf        <= 1'b0;
               end else begin
                  edge_cnt <= sat_cnt;
                  ovf      <= ovf | carry;
                  if (gate_en) tick_cnt <= tick_cnt + TW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: 10-clk gate ticks, 4-tick windows,
// a 32-bit and a 4-bit counter instance driven in parallel.
module tb_freq_meter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        gate_en;
   logic        sig_in;
   logic [31:0] freq;
   logic        freq_valid;
   logic        overflow;
   logic [3:0]  freq4;
   logic        freq_valid4;
   logic        overflow4;

   int vecs    = 0;
   int errs    = 0;
   int cyc_n   = 0;
   int gcnt    = 0;
   int sig_per = 0;
   int phase   = 0;
   int t0      = -1;
   bit gate_on = 1'b0;
   bit want_t0 = 1'b0;
   bit prev_v  = 1'b0;

   always #5 clk = ~clk;

   freq_meter #(
      .CNT_W(32), .TICKS_PER_GATE(4), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .gate_en(gate_en), .sig_in(sig_in),
      .freq(freq), .freq_valid(freq_valid), .overflow(overflow)
   );

   freq_meter #(
      .CNT_W(4), .TICKS_PER_GATE(4), .SYNC_STAGES(2)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .gate_en(gate_en), .sig_in(sig_in),
      .freq(freq4), .freq_valid(freq_valid4), .overflow(overflow4)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clk: advance, then drive gate generator and pattern source.
   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
      if (prev_v) check("valid_width", freq_valid, 0);
      prev_v = freq_valid;
      if (gate_on) begin
         gate_en = (gcnt == 9);
         if (gate_en && want_t0 && rst_n) begin
            t0      = cyc_n + 1;
            want_t0 = 1'b0;
         end
         gcnt = (gcnt == 9) ? 0 : gcnt + 1;
      end else begin
         gate_en = 1'b0;
      end
      if (sig_per > 0) begin
         sig_in = ((phase % sig_per) < (sig_per / 2));
         phase++;
      end
   endtask

   task automatic wait_valid(output int v);
      int n;
      n = 0;
      do begin
         cyc();
         n++;
      end while (!freq_valid && n < 200);
      check("valid_seen", freq_valid, 1);
      check("valid4_seen", freq_valid4, 1);
      v = cyc_n;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, v2;
      rst_n   = 1'b0;
      gate_en = 1'b0;
      sig_in  = 1'b0;
      repeat (3) cyc();
      check("rst_freq", freq, 0);
      check("rst_valid", freq_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_freq4", freq4, 0);
      check("rst_ovf4", overflow4, 0);
      rst_n = 1'b1;

      // Edges with no gate ticks must never produce a strobe
      sig_per = 4;
      phase   = 0;
      repeat (30) begin
         cyc();
         check("idle_valid", freq_valid, 0);
      end
      sig_per = 0;
      sig_in  = 1'b0;
      repeat (5) cyc();

      gcnt    = 9;
      want_t0 = 1'b1;
      gate_on = 1'b1;
      wait_valid(v);
      check("first_valid_at", v, t0 + 40);
      check("silent_freq", freq, 0);
      check("silent_ovf", overflow, 0);
      cyc();
      check("strobe_1clk", freq_valid, 0);
      wait_valid(v2);
      check("silent_period", v2, v + 40);
      check("silent_freq_b", freq, 0);
      check("silent_freq4", freq4, 0);
      check("silent_ovf4", overflow4, 0);

      // Steady 4-clk period: 10 edges per 40-clk window
      sig_per = 4;
      phase   = 0;
      wait_valid(v);
      wait_valid(v2);
      check("steady_period", v2, v + 40);
      check("steady_freq", freq, 10);
      check("steady_ovf", overflow, 0);
      check("steady_freq4", freq4, 10);
      check("steady_ovf4", overflow4, 0);
      repeat (10) cyc();
      check("hold_freq", freq, 10);
      check("hold_valid", freq_valid, 0);
      wait_valid(v);
      check("steady_freq_b", freq, 10);

      // 2-clk period: 20 edges, saturating in the 4-bit instance
      sig_per = 2;
      phase   = 0;
      wait_valid(v);
      wait_valid(v);
      check("fast_freq", freq, 20);
      check("fast_ovf", overflow, 0);
      check("sat_freq4", freq4, 15);
      check("sat_ovf4", overflow4, 1);

      // Reset 20 clks into a window
      repeat (20) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_freq", freq, 0);
      check("mrst_valid", freq_valid, 0);
      check("mrst_ovf", overflow, 0);
      check("mrst_freq4", freq4, 0);
      check("mrst_ovf4", overflow4, 0);
      repeat (5) begin
         cyc();
         check("mrst_hold_valid", freq_valid, 0);
      end
      sig_per = 8;
      phase   = 0;
      rst_n   = 1'b1;
      want_t0 = 1'b1;
      wait_valid(v);
      check("post_rst_valid_at", v, t0 + 40);
      wait_valid(v);
      check("slow_freq", freq, 5);
      check("slow_freq4", freq4, 5);
      check("slow_ovf4", overflow4, 0);

      // Edge landing on the closing-tick clk
      sig_per = 0;
      sig_in  = 1'b0;
      wait_valid(v);
      wait_valid(v);
      check("quiet_freq", freq, 0);
      for (int k = 1; k <= 39; k++) begin
         cyc();
         case (k)
            5, 10, 15, 37: sig_in = 1'b1;
            7, 12, 17, 39: sig_in = 1'b0;
            default: ;
         endcase
      end
      wait_valid(v2);
      check("coinc_valid_at", v2, v + 40);
      check("coinc_freq", freq, 4);
      check("coinc_freq4", freq4, 4);
      wait_valid(v);
      check("coinc_next_freq", freq, 0);
      check("coinc_next_freq4", freq4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
